// File: rtl/pq_pkg.sv
// Shared types, defaults and the LFSR step function for the priority-queue client generator.
package pq_pkg;

  localparam int KW_DEF = 8;
  localparam int VW_DEF = 8;

  // Fibonacci taps 16,14,13,11 expressed as register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    MIX,
    DRAIN,
    CHECK,
    DONE
  } pq_client_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pq_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load; advances only when enabled.
module pq_lfsr16
  import pq_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (enable) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/pq_client_gen.sv
// LFSR-driven enqueue/dequeue generator and result checker for a priority-queue device.
// Defining PQ_CLIENT_MIXED_EN inserts a randomised MIX phase between FILL and DRAIN.
module pq_client_gen
  import pq_pkg::*;
#(
  parameter int          KW    = KW_DEF,
  parameter int          VW    = VW_DEF,
  parameter int          NFILL = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             enq,
  output logic             deq,
  output logic [KW+VW-1:0] kvi,
  input  logic [KW+VW-1:0] kvo,
  input  logic             busy,
  input  logic             full,
  input  logic             empty,
  output logic             done,
  output logic [7:0]       err_cnt,
  output logic [15:0]      n_ops
);

  localparam logic [15:0] NFILL_C = 16'(NFILL);
  localparam int          SW      = KW + 8;

`ifdef PQ_CLIENT_MIXED_EN
  localparam pq_client_state_t FILL_EXIT = MIX;
`else
  localparam pq_client_state_t FILL_EXIT = DRAIN;
`endif

  pq_client_state_t state, state_nx;
  logic [15:0]      lfsr_q;
  logic [15:0]      fill_cnt;
  logic [15:0]      pop_cnt;
  logic [SW-1:0]    sum_in;
  logic [SW-1:0]    sum_out;
  logic [KW-1:0]    prev_key;
  logic [KW-1:0]    key_in;
  logic [KW-1:0]    key_out;
  logic             issue_enq;
  logic             issue_deq;
  logic             op_pend;
  logic             can_op;
  logic             run_start;
  logic             ord_err;
  logic             chk_err;
  logic             unused_bits;
`ifdef PQ_CLIENT_MIXED_EN
  logic [15:0]      mix_cnt;
  logic             mix_slot;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // A registered pulse on enq/deq means an op is still in flight: enforce the one-cycle gap.
  assign op_pend   = enq | deq;
  assign can_op    = !busy && !op_pend;
  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign key_in    = lfsr_q[KW-1:0];
  assign key_out   = kvo[KW+VW-1:VW];
  assign unused_bits = ^{lfsr_q[15:KW], kvo[VW-1:0]};

  assign ord_err = issue_deq && (state == DRAIN) && (pop_cnt != 16'd0) && (key_out < prev_key);
  assign chk_err = (state == CHECK) && ((sum_in != sum_out) || (pop_cnt != fill_cnt));

  pq_lfsr16 #(
    .RST_VAL(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(issue_enq),
    .load  (run_start),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = FILL;
      FILL:  if (((fill_cnt == NFILL_C) || full) && !op_pend) state_nx = FILL_EXIT;
`ifdef PQ_CLIENT_MIXED_EN
      MIX:   if ((mix_cnt == NFILL_C) && !op_pend) state_nx = DRAIN;
`endif
      DRAIN: if (empty && can_op) state_nx = CHECK;
      CHECK: state_nx = DONE;
      DONE:  if (start) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    issue_enq = 1'b0;
    issue_deq = 1'b0;
    done      = 1'b0;
`ifdef PQ_CLIENT_MIXED_EN
    mix_slot  = 1'b0;
`endif
    case (state)
      FILL:  issue_enq = can_op && !full && (fill_cnt < NFILL_C);
`ifdef PQ_CLIENT_MIXED_EN
      MIX: begin
        mix_slot = can_op && (mix_cnt < NFILL_C);
        if (mix_slot) begin
          if (full)            issue_deq = !empty;
          else if (empty)      issue_enq = 1'b1;
          else if (lfsr_q[15]) issue_enq = 1'b1;
          else                 issue_deq = 1'b1;
        end
      end
`endif
      DRAIN: issue_deq = can_op && !empty;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Decision registers: a choice made in cycle t is visible on the port in cycle t+1 only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq <= 1'b0;
      deq <= 1'b0;
      kvi <= '0;
    end else begin
      enq <= issue_enq;
      deq <= issue_deq;
      if (issue_enq) kvi <= {key_in, fill_cnt[VW-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= 8'd0;
      n_ops    <= 16'd0;
      fill_cnt <= 16'd0;
      pop_cnt  <= 16'd0;
      sum_in   <= '0;
      sum_out  <= '0;
      prev_key <= '0;
    end else if (run_start) begin
      err_cnt  <= 8'd0;
      n_ops    <= 16'd0;
      fill_cnt <= 16'd0;
      pop_cnt  <= 16'd0;
      sum_in   <= '0;
      sum_out  <= '0;
      prev_key <= '0;
    end else begin
      if (issue_enq) begin
        sum_in   <= sum_in + {8'd0, key_in};
        fill_cnt <= fill_cnt + 16'd1;
        n_ops    <= n_ops + 16'd1;
      end
      if (issue_deq) begin
        prev_key <= key_out;
        sum_out  <= sum_out + {8'd0, key_out};
        pop_cnt  <= pop_cnt + 16'd1;
        n_ops    <= n_ops + 16'd1;
      end
`ifdef PQ_CLIENT_MIXED_EN
      // The MIX phase leaves arbitrary contents behind; the order check restarts at DRAIN.
      if ((state == MIX) && (state_nx == DRAIN)) prev_key <= '0;
`endif
      if (ord_err || chk_err) err_cnt <= sat_inc(err_cnt);
    end
  end

`ifdef PQ_CLIENT_MIXED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_cnt <= 16'd0;
    end else if (run_start) begin
      mix_cnt <= 16'd0;
    end else if (mix_slot) begin
      mix_cnt <= mix_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pq_client_gen.sv
// Bench for pq_client_gen: behavioural priority queue (normal / LIFO / drop-first) plus vector table.
module tb_pq_client_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        enq, deq, done;
  logic        busy = 1'b0;
  logic        full, empty;
  logic [15:0] kvi, kvo;
  logic [7:0]  err_cnt;
  logic [15:0] n_ops;

  always #5 clk = ~clk;

  pq_client_gen #(
    .KW(8), .VW(8), .NFILL(16), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enq(enq), .deq(deq),
    .kvi(kvi), .kvo(kvo), .busy(busy), .full(full), .empty(empty),
    .done(done), .err_cnt(err_cnt), .n_ops(n_ops)
  );

  // ---------------- behavioural queue: mode 0 min-first, 1 LIFO, 2 drops first enqueue
  int          depth = 8;
  int          mode = 0;
  logic        model_clr = 1'b0;
  logic [15:0] mem [0:31];
  int          cnt = 0;
  logic        dropped = 1'b0;
  int          head_idx;

  always_comb begin
    head_idx = 0;
    if (mode == 1) begin
      head_idx = (cnt > 0) ? cnt - 1 : 0;
    end else begin
      for (int i = 1; i < 32; i++)
        if (i < cnt && mem[i][15:8] < mem[head_idx][15:8]) head_idx = i;
    end
  end

  assign kvo   = (cnt == 0) ? 16'h0000 : mem[head_idx];
  assign full  = (cnt >= depth);
  assign empty = (cnt == 0);

  always @(posedge clk) begin
    if (model_clr) begin
      cnt     <= 0;
      dropped <= 1'b0;
    end else if (enq) begin
      if (mode == 2 && !dropped) dropped <= 1'b1;
      else if (cnt < depth && cnt < 32) begin
        mem[cnt] <= kvi;
        cnt      <= cnt + 1;
      end
    end else if (deq && cnt > 0) begin
      mem[head_idx] <= mem[cnt-1];
      cnt           <= cnt - 1;
    end
  end

  // ---------------- protocol monitor
  int         n_enq = 0, n_deq = 0, gap_viol = 0;
  logic       op_prev = 1'b0, busy_prev = 1'b0;
  logic [15:0] kvi_log [0:31];
  logic [7:0]  pop_log [0:31];

  always @(posedge clk) begin
    op_prev   <= enq | deq;
    busy_prev <= busy;
    if (model_clr) begin
      n_enq    <= 0;
      n_deq    <= 0;
      gap_viol <= 0;
    end else begin
      if (enq) begin
        if (n_enq < 32) kvi_log[n_enq] <= kvi;
        n_enq <= n_enq + 1;
      end
      if (deq) begin
        if (n_deq < 32) pop_log[n_deq] <= kvo[15:8];
        n_deq <= n_deq + 1;
      end
      if ((enq && deq) || ((enq || deq) && (op_prev || busy_prev)) ||
          (enq && full) || (deq && empty))
        gap_viol <= gap_viol + 1;
    end
  end

  // ---------------- checking
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  typedef struct {
    int depth;
    int mode;
    bit stall;
    int exp_enq;
    int exp_deq;
    int exp_err;
    int exp_nops;
  } vec_t;

  vec_t       vecs [0:5];
  logic [7:0] exp_key [0:15];

  task automatic run_vec(input int v);
    int         lim, snap, ne, nd, base;
    logic [7:0] srt [0:15];
    logic [7:0] t;
    depth = vecs[v].depth;
    mode  = vecs[v].mode;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (vecs[v].stall) begin
      lim = 0;
      while (n_enq < 3 && lim < 500) begin @(negedge clk); lim++; end
      busy = 1'b1;
      snap = n_enq;
      start = 1'b1;                 // must be ignored outside IDLE/DONE
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk($sformatf("v%0d_stall_enq", v), 32'(n_enq), 32'(snap));
      busy = 1'b0;
    end
    lim = 0;
    while (!done && lim < 2000) begin @(negedge clk); lim++; end
    chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
    chk($sformatf("v%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].exp_err));
    chk($sformatf("v%0d_n_ops", v), 32'(n_ops), 32'(vecs[v].exp_nops));
    chk($sformatf("v%0d_n_enq", v), 32'(n_enq), 32'(vecs[v].exp_enq));
    chk($sformatf("v%0d_n_deq", v), 32'(n_deq), 32'(vecs[v].exp_deq));
    chk($sformatf("v%0d_gap", v), 32'(gap_viol), 32'd0);
    ne = vecs[v].exp_enq;
    for (int i = 0; i < ne; i++)
      chk($sformatf("v%0d_kvi%0d", v, i), 32'(kvi_log[i]), 32'({exp_key[i], 8'(i)}));
    base = (vecs[v].mode == 2) ? 1 : 0;
    nd   = ne - base;
    for (int i = 0; i < nd; i++) srt[i] = exp_key[i + base];
    for (int i = 0; i < nd; i++)
      for (int j = 0; j + 1 < nd - i; j++)
        if (srt[j] > srt[j+1]) begin t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t; end
    for (int i = 0; i < nd; i++) begin
      if (vecs[v].mode == 1)
        chk($sformatf("v%0d_pop%0d", v, i), 32'(pop_log[i]), 32'(exp_key[ne-1-i]));
      else
        chk($sformatf("v%0d_pop%0d", v, i), 32'(pop_log[i]), 32'(srt[i]));
    end
  endtask

  initial begin
    logic [15:0] x;
    int          lifo_err;
    int          lim;

    x = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      exp_key[i] = x[7:0];
      x = lfsr_step(x);
    end
    // LIFO pops key[15], key[14], ...: a descent occurs wherever key[i] < key[i+1]
    lifo_err = 0;
    for (int i = 0; i < 15; i++) if (exp_key[i] < exp_key[i+1]) lifo_err++;

    //          depth mode stall enq deq err       nops
    vecs[0] = '{8,    0,   1'b0,  8,  8, 0,        16};
    vecs[1] = '{32,   0,   1'b0, 16, 16, 0,        32};
    vecs[2] = '{32,   1,   1'b0, 16, 16, lifo_err, 32};
    vecs[3] = '{32,   2,   1'b0, 16, 15, 1,        31};
    vecs[4] = '{32,   0,   1'b1, 16, 16, 0,        32};
    vecs[5] = '{0,    0,   1'b0,  0,  0, 0,         0};

    repeat (3) @(negedge clk);
    chk("rst_enq", 32'(enq), 32'd0);
    chk("rst_deq", 32'(deq), 32'd0);
    chk("rst_kvi", 32'(kvi), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_n_ops", 32'(n_ops), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_vec(v);
      if (v == 1) begin
        chk("first_kvi", 32'(kvi_log[0]), 32'h0000E100);
        chk("second_kvi", 32'(kvi_log[1]), 32'h0000C301);
      end
      if (v == 2) chk("lifo_err_nonzero", 32'(err_cnt != 8'd0), 32'd1);
    end

    // Reset while draining, then a fresh run must replay the same kvi sequence.
    depth = 32;
    mode  = 0;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = 0;
    while (n_deq < 3 && lim < 1000) begin @(negedge clk); lim++; end
    chk("mid_reached_drain", 32'(n_deq >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enq", 32'(enq), 32'd0);
    chk("mid_rst_deq", 32'(deq), 32'd0);
    chk("mid_rst_kvi", 32'(kvi), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_n_ops", 32'(n_ops), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
